fft_cbfp_shift_norm: RTL and testbench
======================================

# fft_cbfp_shift_norm

Convergent block-floating-point normalisation stage, directly downstream of the per-beat leading-zero-count (LZC) stage in the FFT CBFP path. Collects one CBFP block of `array_num` beats of `array_size` complex samples, finds the block-minimum shift, then left-shifts, rounds and saturates every sample from `din_size` to `dout_size` bits. Emits each sample with the block exponent. Ping-pong banking sustains one beat per cycle with no backpressure.

## Interface
- `array_size`, 16, complex samples per beat
- `array_num`, 4, beats per CBFP block
- `din_size`, 23, input sample width (signed)
- `dout_size`, 11, output sample width (signed)
- `lzc_w`, 5, LZC/exponent width, equal to $clog2(din_size+1)
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `valid_in`  in  1  input beat valid
- `din_re`, `din_im`  in  `array_size` x `din_size`  signed samples
- `lzc_in`  in  `lzc_w`  beat-minimum redundant-sign-bit count over re and im, aligned with `din_*`
- `valid_out`  out  1  output beat valid
- `dout_re`, `dout_im`  out  `array_size` x `dout_size`  normalised samples
- `exp_out`  out  `lzc_w`  block shift applied, constant across the block's beats

## Operation
- Beat counter advances on every `valid_in`. The block closes on the `array_num`-th accepted beat. Gaps in `valid_in` are allowed and only stall the fill.
- Two banks, each with its own state: EMPTY -> FILLING on the first write -> FULL on the closing beat -> DRAINING when selected by the output FSM -> EMPTY after its last beat is read.
- Write bank alternates per block.
- Running minimum: the first beat of a block loads `lzc_in`. Later beats take min(running, `lzc_in`).
- The block shift `s` is latched with the bank at close, clamped to `din_size-1`. An all-zero block gives `lzc_in=23` and therefore `s=22`.
- Output FSM states:
  - IDLE -> DRAIN when a bank is FULL.
  - DRAIN emits beats 0..`array_num-1` in consecutive cycles.
  - On the last drain beat, DRAIN moves directly to the other bank if it is FULL, otherwise to IDLE.
- Per-sample arithmetic is performed in `din_size+1` bits: y = ((x <<< s) + 2^(din_size-dout_size-1)) >>> (din_size-dout_size).
- Rounding is round-half-up (floor after the +half add).
- y saturates to [-2^(dout_size-1), 2^(dout_size-1)-1].
- `exp_out` = `s`.
- No overflow of the banks is possible: a drain takes `array_num` cycles and a fill takes at least `array_num` cycles. The bench asserts that a write into a non-EMPTY bank never occurs.

## Timing
- Reset values: `valid_out`=0, `dout_*`=0, `exp_out`=0. Both banks EMPTY, beat counter 0, FSM IDLE, write pointer on bank 0.
- Reset asserted mid-block or mid-drain discards all partial and pending data. `valid_out` is 0 from the cycle after `rst` is sampled.
- Latency with contiguous input: input beat j of a block in cycle t0+j gives output beat j in cycle t0+j+`array_num`+1. For the defaults this is 5 cycles. The first output appears 2 cycles after the closing beat.
- Outputs are registered. `dout_*`/`exp_out` hold their last values while `valid_out`=0.
- Simultaneous events: bank X closes in the same cycle that bank Y finishes draining -> X starts draining the next cycle, with no bubble.
- Back-to-back contiguous blocks give a gapless `valid_out`.

## Structure
- Shared package `fft_cbfp_pkg` holds:
  - default `array_size`/`array_num`/`din_size`/`dout_size`/`lzc_w` constants;
  - the bank-state enum {EMPTY, FILLING, FULL, DRAINING};
  - the output-FSM enum {IDLE, DRAIN}.
- Sub-module `fft_cbfp_round_sat` is combinational: shift, round, saturate for one sample. It is instantiated 2 x `array_size` times.
- Top level holds the banks, counters, FSM and output registers.

## Test plan
- Reset mid-drain: pulse `rst` during output beat 1 -> `valid_out`=0 the next cycle; no further beats of that block are emitted.
- Uniform block, all samples re=im=256, `lzc_in`=13 on every beat -> all outputs 512, `exp_out`=13, first output 2 cycles after the closing beat.
- Block-minimum shift: same 256 samples, `lzc_in` sequence 13,5,9,13 -> `exp_out`=5, all outputs 2 (8192+2048=10240, >>12 gives 2).
- Saturation and rounding, `lzc_in`=0:
  - x=4194303 -> 1023 (saturated);
  - x=-4194304 -> -1024;
  - x=6144 -> 2 (round half up).
- Zero block with `lzc_in`=23 -> `exp_out`=22, all outputs 0.
- Streaming: 3 contiguous blocks, then a 4th block with single-cycle `valid_in` gaps -> 12 gapless output beats, then 4 more beats, each delayed 2 cycles after its block's closing beat. No write into a non-EMPTY bank.

Source files
------------

// File: rtl/fft_cbfp_pkg.sv
// Shared constants and state encodings for the FFT CBFP normalisation path.
//   ARRAY_SIZE : complex samples per beat
//   ARRAY_NUM  : beats per CBFP block
//   DIN_SIZE   : input sample width (signed)
//   DOUT_SIZE  : output sample width (signed)
//   LZC_W      : LZC / exponent width, $clog2(DIN_SIZE+1)
package fft_cbfp_pkg;

  localparam int unsigned ARRAY_SIZE = 16;
  localparam int unsigned ARRAY_NUM  = 4;
  localparam int unsigned DIN_SIZE   = 23;
  localparam int unsigned DOUT_SIZE  = 11;
  localparam int unsigned LZC_W      = 5;

  // Per-bank occupancy state
  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_e;

  // Output drain FSM
  typedef enum logic {
    IDLE,
    DRAIN
  } fsm_e;

endpackage

// File: rtl/fft_cbfp_round_sat.sv
// Combinational shift / round-half-up / saturate for one sample.
//   x   : signed input sample, din_size bits
//   s   : block left-shift amount
//   y_c : signed normalised sample, dout_size bits
module fft_cbfp_round_sat #(
  parameter int unsigned din_size  = 23,
  parameter int unsigned dout_size = 11,
  parameter int unsigned lzc_w     = 5
) (
  input  logic [din_size-1:0]  x,
  input  logic [lzc_w-1:0]     s,
  output logic [dout_size-1:0] y_c
);

  // One guard bit above the input so the +half add cannot wrap at full scale
  localparam int unsigned ext_w  = din_size + 1;
  localparam int unsigned frac_w = din_size - dout_size;

  localparam logic signed [ext_w-1:0] half   = ext_w'(1 << (frac_w - 1));
  localparam logic signed [ext_w-1:0] sat_hi = ext_w'((1 << (dout_size - 1)) - 1);
  localparam logic signed [ext_w-1:0] sat_lo = ~sat_hi;

  logic signed [ext_w-1:0] sh_c;
  logic signed [ext_w-1:0] sum_c;
  logic signed [ext_w-1:0] q_c;

  // Shift, add half LSB, floor, clamp
  always_comb begin
    sh_c  = $signed({x[din_size-1], x}) <<< s;
    sum_c = sh_c + half;
    q_c   = sum_c >>> frac_w;
    if (q_c > sat_hi) begin
      y_c = sat_hi[dout_size-1:0];
    end else if (q_c < sat_lo) begin
      y_c = sat_lo[dout_size-1:0];
    end else begin
      y_c = q_c[dout_size-1:0];
    end
  end

endmodule

// File: rtl/fft_cbfp_shift_norm.sv
// CBFP normalisation stage: buffers one block per ping-pong bank, tracks the
// block-minimum LZC, then drains each bank shifted/rounded/saturated with the
// block exponent.
//   clk, rst         : clock, synchronous active-high reset
//   valid_in         : input beat valid
//   din_re/din_im    : array_size x din_size signed samples
//   lzc_in           : beat-minimum redundant-sign-bit count
//   valid_out        : output beat valid
//   dout_re/dout_im  : array_size x dout_size normalised samples
//   exp_out          : block shift applied
module fft_cbfp_shift_norm
  import fft_cbfp_pkg::*;
#(
  parameter int unsigned array_size = ARRAY_SIZE,
  parameter int unsigned array_num  = ARRAY_NUM,
  parameter int unsigned din_size   = DIN_SIZE,
  parameter int unsigned dout_size  = DOUT_SIZE,
  parameter int unsigned lzc_w      = LZC_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  valid_in,
  input  logic [array_size-1:0][din_size-1:0]   din_re,
  input  logic [array_size-1:0][din_size-1:0]   din_im,
  input  logic [lzc_w-1:0]                      lzc_in,
  output logic                                  valid_out,
  output logic [array_size-1:0][dout_size-1:0]  dout_re,
  output logic [array_size-1:0][dout_size-1:0]  dout_im,
  output logic [lzc_w-1:0]                      exp_out
);

  localparam int unsigned        cnt_w     = (array_num > 1) ? $clog2(array_num) : 1;
  localparam logic [cnt_w-1:0]   last_beat = cnt_w'(array_num - 1);
  localparam logic [lzc_w-1:0]   max_shift = lzc_w'(din_size - 1);

  typedef logic [array_size-1:0][din_size-1:0]  beat_t;
  typedef logic [array_size-1:0][dout_size-1:0] obeat_t;

  beat_t              mem_re_q [2][array_num];
  beat_t              mem_im_q [2][array_num];

  bank_st_e           bank_st_q [2];
  bank_st_e           bank_st_d [2];
  logic [lzc_w-1:0]   shift_q [2];
  logic [lzc_w-1:0]   shift_d [2];
  logic               wr_bank_q, wr_bank_d;
  logic [cnt_w-1:0]   wr_cnt_q, wr_cnt_d;
  logic [lzc_w-1:0]   min_q, min_d;
  fsm_e               fsm_q, fsm_d;
  logic               rd_bank_q, rd_bank_d;
  logic [cnt_w-1:0]   rd_cnt_q, rd_cnt_d;
  logic               valid_out_q, valid_out_d;
  obeat_t             dout_re_q, dout_re_d;
  obeat_t             dout_im_q, dout_im_d;
  logic [lzc_w-1:0]   exp_q, exp_d;

  logic               wr_en_c;
  logic               emit_c;
  logic [lzc_w-1:0]   run_min_c;
  logic [lzc_w-1:0]   rd_shift_c;
  obeat_t             rs_re_c, rs_im_c;

  assign rd_shift_c = shift_q[rd_bank_q];

  // Sample datapath on the bank/beat currently being read
  for (genvar i = 0; i < array_size; i++) begin : g_rs
    fft_cbfp_round_sat #(
      .din_size (din_size),
      .dout_size(dout_size),
      .lzc_w    (lzc_w)
    ) u_re (
      .x  (mem_re_q[rd_bank_q][rd_cnt_q][i]),
      .s  (rd_shift_c),
      .y_c(rs_re_c[i])
    );
    fft_cbfp_round_sat #(
      .din_size (din_size),
      .dout_size(dout_size),
      .lzc_w    (lzc_w)
    ) u_im (
      .x  (mem_im_q[rd_bank_q][rd_cnt_q][i]),
      .s  (rd_shift_c),
      .y_c(rs_im_c[i])
    );
  end

  // Next-state: fill side, then drain side (the two never touch the same bank)
  always_comb begin
    bank_st_d   = bank_st_q;
    shift_d     = shift_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    min_d       = min_q;
    fsm_d       = fsm_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    valid_out_d = 1'b0;
    dout_re_d   = dout_re_q;
    dout_im_d   = dout_im_q;
    exp_d       = exp_q;
    wr_en_c     = 1'b0;
    emit_c      = 1'b0;
    run_min_c   = lzc_in;

    if (valid_in) begin
      wr_en_c = 1'b1;
      if ((wr_cnt_q != '0) && (min_q < lzc_in)) begin
        run_min_c = min_q;
      end
      min_d = run_min_c;
      if (wr_cnt_q == last_beat) begin
        bank_st_d[wr_bank_q] = FULL;
        shift_d[wr_bank_q]   = (run_min_c > max_shift) ? max_shift : run_min_c;
        wr_cnt_d             = '0;
        wr_bank_d            = ~wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = FILLING;
        wr_cnt_d             = wr_cnt_q + 1'b1;
      end
    end

    // Beat 0 is emitted straight out of IDLE so output lands 2 cycles after close
    case (fsm_q)
      IDLE: begin
        if (bank_st_q[rd_bank_q] == FULL) begin
          emit_c = 1'b1;
          fsm_d  = DRAIN;
        end
      end
      DRAIN:   emit_c = 1'b1;
      default: emit_c = 1'b0;
    endcase

    if (emit_c) begin
      valid_out_d = 1'b1;
      dout_re_d   = rs_re_c;
      dout_im_d   = rs_im_c;
      exp_d       = rd_shift_c;
      if (rd_cnt_q == last_beat) begin
        bank_st_d[rd_bank_q] = EMPTY;
        rd_bank_d            = ~rd_bank_q;
        rd_cnt_d             = '0;
        fsm_d                = (bank_st_q[~rd_bank_q] == FULL) ? DRAIN : IDLE;
      end else begin
        bank_st_d[rd_bank_q] = DRAINING;
        rd_cnt_d             = rd_cnt_q + 1'b1;
      end
    end
  end

  // Sample storage, no reset needed: bank state gates every read
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_re_q[wr_bank_q][wr_cnt_q] <= din_re;
      mem_im_q[wr_bank_q][wr_cnt_q] <= din_im;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q   <= '{EMPTY, EMPTY};
      shift_q     <= '{default: '0};
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      min_q       <= '0;
      fsm_q       <= IDLE;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      valid_out_q <= 1'b0;
      dout_re_q   <= '0;
      dout_im_q   <= '0;
      exp_q       <= '0;
    end else begin
      bank_st_q   <= bank_st_d;
      shift_q     <= shift_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      min_q       <= min_d;
      fsm_q       <= fsm_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      valid_out_q <= valid_out_d;
      dout_re_q   <= dout_re_d;
      dout_im_q   <= dout_im_d;
      exp_q       <= exp_d;
    end
  end

  assign valid_out = valid_out_q;
  assign dout_re   = dout_re_q;
  assign dout_im   = dout_im_q;
  assign exp_out   = exp_q;

endmodule

// File: tb/tb_fft_cbfp_shift_norm.sv
// Directed self-checking bench for fft_cbfp_shift_norm.
module tb_fft_cbfp_shift_norm;

  localparam int AS = 16;
  localparam int DW = 23;
  localparam int OW = 11;
  localparam int LW = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_in;
  logic [AS-1:0][DW-1:0]   din_re;
  logic [AS-1:0][DW-1:0]   din_im;
  logic [LW-1:0]           lzc_in;
  logic                    valid_out;
  logic [AS-1:0][OW-1:0]   dout_re;
  logic [AS-1:0][OW-1:0]   dout_im;
  logic [LW-1:0]           exp_out;

  int tests_run    = 0;
  int tests_failed = 0;
  int ovf_errs     = 0;

  fft_cbfp_shift_norm dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .din_re   (din_re),
    .din_im   (din_im),
    .lzc_in   (lzc_in),
    .valid_out(valid_out),
    .dout_re  (dout_re),
    .dout_im  (dout_im),
    .exp_out  (exp_out)
  );

  always #5 clk = ~clk;

  // A block's first beat must land in an EMPTY bank
  always @(posedge clk) begin
    if (!rst && valid_in && (dut.wr_cnt_q == '0) &&
        (dut.bank_st_q[dut.wr_bank_q] != fft_cbfp_pkg::EMPTY)) begin
      ovf_errs <= ovf_errs + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int re, input int im);
    for (int i = 0; i < AS; i++) begin
      din_re[i] = DW'(re);
      din_im[i] = DW'(im);
    end
  endtask

  // Four contiguous beats of the current din_* with per-beat lzc; returns in the
  // cycle right after the closing beat with valid_in low.
  task automatic drive_block(input int l0, input int l1, input int l2, input int l3);
    int lz [4];
    lz = '{l0, l1, l2, l3};
    for (int b = 0; b < 4; b++) begin
      valid_in = 1'b1;
      lzc_in   = LW'(lz[b]);
      tick();
    end
    valid_in = 1'b0;
    lzc_in   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid got %b want 0", valid_out);
    end
    tests_run++;
    if (dout_re !== '0 || dout_im !== '0) begin
      tests_failed++; $display("FAIL reset_dout got %h/%h want 0", dout_re[0], dout_im[0]);
    end
    tests_run++;
    if (exp_out !== '0) begin
      tests_failed++; $display("FAIL reset_exp got %0d want 0", exp_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_uniform();
    set_all(256, 256);
    drive_block(13, 13, 13, 13);
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++; $display("FAIL uniform_early got %b want 0", valid_out);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      tests_run++;
      if (valid_out !== 1'b1 || exp_out !== 5'd13) begin
        tests_failed++;
        $display("FAIL uniform_beat%0d got v=%b e=%0d want v=1 e=13", b, valid_out, exp_out);
      end
      for (int i = 0; i < AS; i++) begin
        tests_run++;
        if (dout_re[i] !== 11'd512 || dout_im[i] !== 11'd512) begin
          tests_failed++;
          $display("FAIL uniform_data b%0d i%0d got %0d/%0d want 512", b, i,
                   $signed(dout_re[i]), $signed(dout_im[i]));
        end
      end
    end
    tick();
    tests_run++;
    if (valid_out !== 1'b0 || dout_re[0] !== 11'd512 || exp_out !== 5'd13) begin
      tests_failed++;
      $display("FAIL uniform_hold got v=%b d=%0d e=%0d want v=0 d=512 e=13",
               valid_out, dout_re[0], exp_out);
    end
    tick();
  endtask

  task automatic test_min_shift();
    set_all(256, 256);
    drive_block(13, 5, 9, 13);
    for (int b = 0; b < 4; b++) begin
      tick();
      tests_run++;
      if (valid_out !== 1'b1 || exp_out !== 5'd5) begin
        tests_failed++;
        $display("FAIL minshift_beat%0d got v=%b e=%0d want v=1 e=5", b, valid_out, exp_out);
      end
      for (int i = 0; i < AS; i++) begin
        tests_run++;
        if (dout_re[i] !== 11'd2 || dout_im[i] !== 11'd2) begin
          tests_failed++;
          $display("FAIL minshift_data b%0d i%0d got %0d/%0d want 2", b, i,
                   $signed(dout_re[i]), $signed(dout_im[i]));
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_sat_round();
    logic [OW-1:0] er [AS];
    logic [OW-1:0] ei [AS];
    for (int i = 0; i < AS; i++) begin
      case (i % 4)
        0: begin din_re[i] = DW'(4194303);  er[i] = 11'd1023;
                 din_im[i] = DW'(-6144);    ei[i] = OW'(-1); end
        1: begin din_re[i] = DW'(-4194304); er[i] = OW'(-1024);
                 din_im[i] = DW'(2048);     ei[i] = 11'd1; end
        2: begin din_re[i] = DW'(6144);     er[i] = 11'd2;
                 din_im[i] = DW'(2047);     ei[i] = 11'd0; end
        default: begin din_re[i] = DW'(6143); er[i] = 11'd1;
                 din_im[i] = DW'(-2049);    ei[i] = OW'(-1); end
      endcase
    end
    drive_block(0, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      tests_run++;
      if (valid_out !== 1'b1 || exp_out !== 5'd0) begin
        tests_failed++;
        $display("FAIL satround_beat%0d got v=%b e=%0d want v=1 e=0", b, valid_out, exp_out);
      end
      for (int i = 0; i < AS; i++) begin
        tests_run++;
        if (dout_re[i] !== er[i] || dout_im[i] !== ei[i]) begin
          tests_failed++;
          $display("FAIL satround_data b%0d i%0d got %0d/%0d want %0d/%0d", b, i,
                   $signed(dout_re[i]), $signed(dout_im[i]), $signed(er[i]), $signed(ei[i]));
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_zero_block();
    set_all(0, 0);
    drive_block(23, 23, 23, 23);
    for (int b = 0; b < 4; b++) begin
      tick();
      tests_run++;
      if (valid_out !== 1'b1 || exp_out !== 5'd22) begin
        tests_failed++;
        $display("FAIL zero_beat%0d got v=%b e=%0d want v=1 e=22", b, valid_out, exp_out);
      end
      tests_run++;
      if (dout_re !== '0 || dout_im !== '0) begin
        tests_failed++;
        $display("FAIL zero_data b%0d got %0d/%0d want 0", b, dout_re[0], dout_im[0]);
      end
    end
    tick();
    tick();
  endtask

  // Blocks 0-2 contiguous, block 3 with one-cycle gaps; block b uses shift b
  task automatic test_back_to_back();
    int blk, beat, v;
    logic        exp_v;
    logic [OW-1:0] e_re, e_im;
    valid_in = 1'b0;
    for (int n = 0; n < 26; n++) begin
      exp_v = 1'b0;
      blk   = 0;
      beat  = 0;
      if (n >= 5 && n <= 16) begin
        exp_v = 1'b1; blk = (n - 5) / 4; beat = (n - 5) % 4;
      end else if (n >= 20 && n <= 23) begin
        exp_v = 1'b1; blk = 3; beat = n - 20;
      end
      tests_run++;
      if (valid_out !== exp_v) begin
        tests_failed++;
        $display("FAIL stream_valid n%0d got %b want %b", n, valid_out, exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (exp_out !== LW'(blk)) begin
          tests_failed++;
          $display("FAIL stream_exp n%0d got %0d want %0d", n, exp_out, blk);
        end
        for (int i = 0; i < AS; i++) begin
          v    = (blk * 4 + beat + 1) * 16 + i;
          e_re = OW'(v);
          e_im = OW'(-v);
          tests_run++;
          if (dout_re[i] !== e_re || dout_im[i] !== e_im) begin
            tests_failed++;
            $display("FAIL stream_data n%0d i%0d got %0d/%0d want %0d/%0d", n, i,
                     $signed(dout_re[i]), $signed(dout_im[i]), v, -v);
          end
        end
      end
      // Inputs for this cycle
      valid_in = 1'b0;
      if (n < 12) begin
        valid_in = 1'b1; blk = n / 4; beat = n % 4;
      end else if (n >= 12 && n <= 18 && (n % 2 == 0)) begin
        valid_in = 1'b1; blk = 3; beat = (n - 12) / 2;
      end
      if (valid_in) begin
        for (int i = 0; i < AS; i++) begin
          v = ((blk * 4 + beat + 1) * 16 + i) << (12 - blk);
          din_re[i] = DW'(v);
          din_im[i] = DW'(-v);
        end
        lzc_in = (beat == 2) ? LW'(blk) : LW'(blk + 2);
      end
      tick();
    end
    tests_run++;
    if (ovf_errs !== 0) begin
      tests_failed++;
      $display("FAIL stream_bank_overwrite got %0d want 0", ovf_errs);
    end
  endtask

  task automatic test_reset_mid_drain();
    set_all(256, 256);
    drive_block(12, 12, 12, 12);
    tick();
    tick();
    tests_run++;
    if (valid_out !== 1'b1 || dout_re[3] !== 11'd256 || exp_out !== 5'd12) begin
      tests_failed++;
      $display("FAIL middrain_beat1 got v=%b d=%0d e=%0d want v=1 d=256 e=12",
               valid_out, dout_re[3], exp_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (valid_out !== 1'b0 || dout_re !== '0 || exp_out !== '0) begin
      tests_failed++;
      $display("FAIL middrain_rst got v=%b d=%0d e=%0d want 0", valid_out, dout_re[0], exp_out);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (valid_out !== 1'b0) begin
        tests_failed++; $display("FAIL middrain_residue c%0d got %b want 0", k, valid_out);
      end
    end
    // Partial fill then reset: the next block must start from beat 0
    valid_in = 1'b1;
    lzc_in   = 5'd12;
    tick();
    tick();
    valid_in = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    drive_block(13, 13, 13, 13);
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++; $display("FAIL midfill_early got %b want 0", valid_out);
    end
    tick();
    tests_run++;
    if (valid_out !== 1'b1 || dout_re[0] !== 11'd512 || exp_out !== 5'd13) begin
      tests_failed++;
      $display("FAIL midfill_recover got v=%b d=%0d e=%0d want v=1 d=512 e=13",
               valid_out, dout_re[0], exp_out);
    end
    for (int k = 0; k < 4; k++) tick();
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    din_re   = '0;
    din_im   = '0;
    lzc_in   = '0;
    test_reset();
    test_uniform();
    test_min_shift();
    test_sat_round();
    test_zero_block();
    test_back_to_back();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
